// File: rtl/key_debounce_pulse.sv
// key_debounce_pulse: conditions one raw active-low push-button.
// A two-flop synchroniser feeds a run-length debounce counter. A small FSM
// turns the accepted level into press/release pulses and a Step pulse that
// can auto-repeat while the key is held. Every output comes from a flop, so
// no combinational path exists from KEY_N to an output.
module key_debounce_pulse #(
  parameter int STABLE_CYCLES = 1000000,
  parameter int REPEAT_EN     = 1,
  parameter int REPEAT_DELAY  = 25000000,
  parameter int REPEAT_RATE   = 5000000
) (
  input  logic Clk,
  input  logic Clr,
  input  logic KEY_N,
  output logic Pressed,
  output logic Press_pulse,
  output logic Release_pulse,
  output logic Step
);

  typedef enum logic [1:0] {
    S_RELEASED = 2'd0,
    S_HOLD     = 2'd1,
    S_REPEAT   = 2'd2
  } state_t;

  // Terminal counts. Each counter clears on its terminal count, so it never
  // wraps for any parameter value below 2^27.
  localparam logic [26:0] STABLE_LAST = 27'(STABLE_CYCLES - 1);
  localparam logic [26:0] DELAY_LAST  = 27'(REPEAT_DELAY - 1);
  localparam logic [26:0] RATE_LAST   = 27'(REPEAT_RATE - 1);

  logic        sync1;
  logic        sync2;
  logic [26:0] db_cnt;
  logic [26:0] timer;
  logic [26:0] timer_d;
  state_t      state;
  state_t      state_d;
  logic        press_d;
  logic        release_d;
  logic        step_d;

  logic key_down;
  logic level_pressed;
  logic disagree;
  logic stable_done;
  logic accept_press;
  logic accept_release;

  // Two-stage synchroniser; both stages reset to the released value (1).
  // NOTE: clocked state uses non-blocking assignments so that every flop
  // samples the pre-edge values, which makes sync2 a true second stage.
  always_ff @(posedge Clk or posedge Clr) begin
    if (Clr) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
    end else begin
      sync1 <= KEY_N;
      sync2 <= sync1;
    end
  end

  // The debounced level is the FSM itself: anything but RELEASED is pressed.
  assign key_down       = ~sync2;
  assign level_pressed  = (state != S_RELEASED);
  assign disagree       = (key_down != level_pressed);
  assign stable_done    = disagree && (db_cnt == STABLE_LAST);
  assign accept_press   = stable_done && !level_pressed;
  assign accept_release = stable_done && level_pressed;

  // Debounce counter: counts consecutive disagreeing samples; any agreeing
  // sample, or acceptance of the new level, restarts it from zero.
  always_ff @(posedge Clk or posedge Clr) begin
    if (Clr) begin
      db_cnt <= '0;
    end else if (!disagree || stable_done) begin
      db_cnt <= '0;
    end else begin
      db_cnt <= db_cnt + 27'd1;
    end
  end

  // Next-state, repeat-timer and pulse decode.
  // NOTE: every variable gets a default before the case so that no path
  // leaves one unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d   = state;
    timer_d   = timer;
    press_d   = 1'b0;
    release_d = 1'b0;
    step_d    = 1'b0;
    case (state)
      S_RELEASED: begin
        timer_d = '0;
        if (accept_press) begin
          state_d = S_HOLD;
          press_d = 1'b1;
          step_d  = 1'b1;
        end
      end
      S_HOLD: begin
        if (accept_release) begin
          state_d   = S_RELEASED;
          release_d = 1'b1;
          timer_d   = '0;
        end else if (timer == DELAY_LAST) begin
          // Without auto-repeat the timer parks here until release.
          if (REPEAT_EN != 0) begin
            state_d = S_REPEAT;
            step_d  = 1'b1;
            timer_d = '0;
          end
        end else begin
          timer_d = timer + 27'd1;
        end
      end
      S_REPEAT: begin
        // A release accepted on a repeat boundary wins; no Step that cycle.
        if (accept_release) begin
          state_d   = S_RELEASED;
          release_d = 1'b1;
          timer_d   = '0;
        end else if (timer == RATE_LAST) begin
          step_d  = 1'b1;
          timer_d = '0;
        end else begin
          timer_d = timer + 27'd1;
        end
      end
      default: begin
        state_d = S_RELEASED;
        timer_d = '0;
      end
    endcase
  end

  // State, timer and registered outputs.
  // NOTE: the asynchronous reset clears outputs immediately, so no pulse
  // can appear while Clr is asserted.
  always_ff @(posedge Clk or posedge Clr) begin
    if (Clr) begin
      state         <= S_RELEASED;
      timer         <= '0;
      Pressed       <= 1'b0;
      Press_pulse   <= 1'b0;
      Release_pulse <= 1'b0;
      Step          <= 1'b0;
    end else begin
      state         <= state_d;
      timer         <= timer_d;
      Pressed       <= (state_d != S_RELEASED);
      Press_pulse   <= press_d;
      Release_pulse <= release_d;
      Step          <= step_d;
    end
  end

endmodule

// File: tb/tb_key_debounce_pulse.sv
// Bench for key_debounce_pulse with STABLE_CYCLES=4, REPEAT_DELAY=10,
// REPEAT_RATE=3. Two instances share the key: one with auto-repeat, one
// without. A run-length/schedule reference model is compared every cycle,
// a constant table covers a clean press/release, and hand sequences cover
// bounce, auto-repeat, release priority and reset mid-repeat.
module tb_key_debounce_pulse;

  localparam int SC = 4;
  localparam int RD = 10;
  localparam int RR = 3;

  logic Clk = 1'b0;
  logic Clr;
  logic KEY_N;
  logic pressed_a, press_a, release_a, step_a;
  logic pressed_b, press_b, release_b, step_b;

  key_debounce_pulse #(
    .STABLE_CYCLES(SC), .REPEAT_EN(1), .REPEAT_DELAY(RD), .REPEAT_RATE(RR)
  ) dut_a (
    .Clk(Clk), .Clr(Clr), .KEY_N(KEY_N),
    .Pressed(pressed_a), .Press_pulse(press_a),
    .Release_pulse(release_a), .Step(step_a)
  );

  key_debounce_pulse #(
    .STABLE_CYCLES(SC), .REPEAT_EN(0), .REPEAT_DELAY(RD), .REPEAT_RATE(RR)
  ) dut_b (
    .Clk(Clk), .Clr(Clr), .KEY_N(KEY_N),
    .Pressed(pressed_b), .Press_pulse(press_b),
    .Release_pulse(release_b), .Step(step_b)
  );

  always #5 Clk = ~Clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Reference model: the synchroniser is a two-sample delay line, the
  // debouncer is a run length of samples that differ from the accepted
  // level, and Step is a schedule measured from the press edge.
  bit dly[$];
  int m_edge, m_run, m_pedge;
  bit m_lvl, m_press, m_rel, m_step_a, m_step_b;

  function automatic void model_reset();
    dly      = {1'b1, 1'b1};
    m_edge   = 0;
    m_run    = 0;
    m_pedge  = 0;
    m_lvl    = 1'b0;
    m_press  = 1'b0;
    m_rel    = 1'b0;
    m_step_a = 1'b0;
    m_step_b = 1'b0;
  endfunction

  function automatic void model_edge(input bit key);
    bit s2;
    s2 = dly[0];
    void'(dly.pop_front());
    dly.push_back(key);
    m_edge++;
    m_press = 1'b0;
    m_rel   = 1'b0;
    if ((s2 == 1'b0) != m_lvl) m_run++;
    else m_run = 0;
    if (m_run == SC) begin
      m_run = 0;
      m_lvl = !m_lvl;
      if (m_lvl) begin
        m_press = 1'b1;
        m_pedge = m_edge;
      end else begin
        m_rel = 1'b1;
      end
    end
    m_step_b = m_press;
    m_step_a = m_press ||
               (m_lvl && (m_edge >= m_pedge + RD) && ((m_edge - m_pedge - RD) % RR == 0));
  endfunction

  // One clock: drive the key, advance the model at the edge, compare on the
  // falling edge.
  task automatic tick(input logic k);
    KEY_N = k;
    @(posedge Clk);
    if (Clr) model_reset();
    else model_edge(k);
    @(negedge Clk);
    check("model_a", {28'd0, pressed_a, press_a, release_a, step_a},
          {28'd0, m_lvl, m_press, m_rel, m_step_a});
    check("model_b", {28'd0, pressed_b, press_b, release_b, step_b},
          {28'd0, m_lvl, m_press, m_rel, m_step_b});
  endtask

  // Assert Clr between edges and confirm outputs drop without a clock.
  task automatic async_reset(input string name);
    Clr = 1'b1;
    #1;
    model_reset();
    check(name, {24'd0, pressed_a, press_a, release_a, step_a,
                 pressed_b, press_b, release_b, step_b}, 32'd0);
  endtask

  typedef struct {
    logic       key;
    logic [3:0] exp;   // {Pressed, Press_pulse, Release_pulse, Step} of dut_a
  } vec_t;

  vec_t tbl[16];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int press_at, rel_at, pulses, steps_a, steps_b, bad_offs, late_steps;

    // Clean press/release, hand-derived: press accepted at edge 6, release
    // (key up before edge 9) accepted at edge 14.
    for (int i = 0; i < 16; i++) begin
      tbl[i].key = (i < 8) ? 1'b0 : 1'b1;
      if (i < 5)       tbl[i].exp = 4'b0000;
      else if (i == 5) tbl[i].exp = 4'b1101;
      else if (i < 13) tbl[i].exp = 4'b1000;
      else if (i == 13) tbl[i].exp = 4'b0010;
      else             tbl[i].exp = 4'b0000;
    end

    // Reset with key released, then 50 quiet cycles.
    model_reset();
    Clr   = 1'b1;
    KEY_N = 1'b1;
    for (int i = 0; i < 3; i++) tick(1'b1);
    Clr = 1'b0;
    pulses = 0;
    for (int i = 0; i < 50; i++) begin
      tick(1'b1);
      pulses += int'(press_a) + int'(release_a) + int'(step_a) + int'(pressed_a);
    end
    check("reset_quiet", pulses, 0);

    // Table-driven clean press and release.
    for (int i = 0; i < 16; i++) begin
      tick(tbl[i].key);
      check($sformatf("table[%0d]", i), {28'd0, pressed_a, press_a, release_a, step_a},
            {28'd0, tbl[i].exp});
    end
    for (int i = 0; i < 4; i++) tick(1'b1);

    // Bounce: 3 low / 1 high five times, then a stable low.
    pulses = 0;
    for (int r = 0; r < 5; r++) begin
      for (int i = 0; i < 3; i++) begin
        tick(1'b0);
        pulses += int'(press_a) + int'(step_a);
      end
      tick(1'b1);
      pulses += int'(press_a) + int'(step_a);
    end
    check("bounce_no_pulse", pulses, 0);

    // Stable low: press at edge 6, then hold 40 more cycles.
    press_at = -1; pulses = 0; steps_a = 0; steps_b = 0; bad_offs = 0;
    for (int i = 1; i <= 46; i++) begin
      tick(1'b0);
      if (press_a) begin
        pulses++;
        if (press_at < 0) press_at = i;
      end
      if (step_b) steps_b++;
      if (step_a) begin
        steps_a++;
        if (press_at >= 0) begin
          int o;
          o = i - press_at;
          if (!(o == 0 || (o >= RD && (o - RD) % RR == 0))) bad_offs++;
        end else begin
          bad_offs++;
        end
      end
    end
    check("bounce_press_edge", press_at, 6);
    check("bounce_single_press", pulses, 1);
    check("repeat_step_count", steps_a, 12);
    check("repeat_step_offsets", bad_offs, 0);
    check("norepeat_step_count", steps_b, 1);

    // Release: accepted at the 6th edge, which coincides with a repeat
    // boundary (offset 46), so Step must stay low there.
    rel_at = -1; late_steps = 0;
    for (int j = 1; j <= 12; j++) begin
      tick(1'b1);
      if (release_a && rel_at < 0) rel_at = j;
      if (j == 6) begin
        check("release_b_edge", {31'd0, release_b}, 32'd1);
        check("release_priority_step", {31'd0, step_a}, 32'd0);
      end
      if (j >= 6) late_steps += int'(step_a) + int'(step_b);
    end
    check("release_edge", rel_at, 6);
    check("no_step_after_release", late_steps, 0);

    // Reset mid-repeat with the key held, then re-press after reset.
    for (int i = 0; i < 20; i++) tick(1'b0);
    async_reset("reset_mid_repeat");
    tick(1'b0);
    tick(1'b0);
    Clr = 1'b0;
    press_at = -1;
    for (int i = 1; i <= 8; i++) begin
      tick(1'b0);
      if (press_a && step_a && press_at < 0) press_at = i;
    end
    check("repress_after_reset", press_at, 6);
    for (int i = 0; i < 8; i++) tick(1'b1);

    // Random key activity with occasional resets.
    for (int s = 0; s < 400; s++) begin
      logic lv;
      int len;
      lv  = 1'($urandom_range(0, 1));
      len = int'($urandom_range(1, 8));
      if ($urandom_range(0, 40) == 0) begin
        async_reset("random_reset");
        tick(lv);
        Clr = 1'b0;
      end
      for (int i = 0; i < len; i++) tick(lv);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/key_debounce_pulse.md
# key_debounce_pulse

Conditions one raw, active-low push-button (KEY) for the board-level counters. Synchronises the asynchronous key and filters contact bounce into a clean level. Emits single-cycle press/release pulses and a Step pulse with optional auto-repeat. Step drives a counter's enable or count input directly, replacing raw KEY-as-clock use.

## Interface
- STABLE_CYCLES, 1000000: consecutive cycles a new synchronised key value must persist before it is accepted (20 ms at 50 MHz); legal range 1..2^27-1.
- REPEAT_EN, 1: 1 enables auto-repeat on Step; 0 gives one Step per press.
- REPEAT_DELAY, 25000000: cycles from press pulse to first repeat Step (0.5 s); legal range 1..2^27-1.
- REPEAT_RATE, 5000000: cycles between subsequent repeat Steps (0.1 s); legal range 1..2^27-1.
- Clk  input  1  system clock (CLOCK_50 at top level).
- Clr  input  1  asynchronous, active-high reset.
- KEY_N  input  1  raw key, 0 = pressed, asynchronous to Clk.
- Pressed  output  1  debounced level, 1 = pressed; reset 0.
- Press_pulse  output  1  one-cycle pulse on accepted press; reset 0.
- Release_pulse  output  1  one-cycle pulse on accepted release; reset 0.
- Step  output  1  one-cycle pulse on press and on each auto-repeat; reset 0.

## Operation
- Synchroniser: two flops on KEY_N, both reset to 1 (released). sync2 is the second stage.
- Debounce counter: 27 bits, reset 0.
  - sync2 agrees with the debounced level: the counter clears.
  - sync2 disagrees and count < STABLE_CYCLES-1: the counter increments.
  - sync2 disagrees and count == STABLE_CYCLES-1: on the next edge the level takes the sync2 value and the counter clears.
  - Any single agreeing sample restarts the count, so glitches shorter than STABLE_CYCLES are never accepted.
- FSM states: RELEASED (reset), HOLD, REPEAT. One 27-bit repeat timer, reset 0.
  - RELEASED -> HOLD on accepted press: Press_pulse=1 and Step=1 in that cycle; timer cleared.
  - HOLD: timer increments. When timer reaches REPEAT_DELAY-1 and REPEAT_EN=1: Step=1, go to REPEAT, timer clears. With REPEAT_EN=0, stay in HOLD and the timer holds.
  - REPEAT: timer increments. At REPEAT_RATE-1: Step=1, timer clears, stay in REPEAT.
  - HOLD or REPEAT -> RELEASED on accepted release: Release_pulse=1, Step=0, timer cleared.
  - A release accepted in the same cycle a repeat Step would fire takes priority. Step is 0 in that cycle.
- Pressed equals (state != RELEASED).
- Outputs are registered. No combinational path exists from KEY_N to any output.
- Counters never wrap. The compare-and-clear happens before overflow for all legal parameters.

## Timing
- A KEY_N change that arrives before edge 1 and is held appears on sync2 after edge 2. Pressed and the pulse update at edge 2+STABLE_CYCLES. Latency = STABLE_CYCLES+2 cycles.
- The first repeat Step comes REPEAT_DELAY cycles after Press_pulse. Later Steps are REPEAT_RATE cycles apart.
- Press_pulse, Release_pulse and Step are high for exactly one cycle. Press_pulse and Release_pulse are never high together.
- Clr asserted at any time: all outputs, the synchroniser (to 1), both counters and the FSM return to reset values immediately. No pulse is emitted during reset.
- If the key is held through Clr deassertion, it is treated as a new press. Press_pulse and Step fire STABLE_CYCLES+2 edges after release of reset.

## Test plan
Benches use STABLE_CYCLES=4, REPEAT_DELAY=10, REPEAT_RATE=3.
- Reset: assert Clr with KEY_N=1 -> all outputs 0 during reset and after release; no pulse within 50 cycles.
- Clean press: KEY_N 1->0 before edge 1, held 8 cycles -> Pressed, Press_pulse and Step rise at edge 6; the pulses are 1 cycle; Pressed stays 1.
- Bounce: KEY_N low for 3 cycles, high 1 cycle, repeated 5 times, then low -> no pulse during bounce; a single Press_pulse 6 edges after the final stable low begins.
- Auto-repeat: hold 40 cycles after press -> Steps at press+0, +10, +13, +16, ...; Release_pulse 6 edges after KEY_N returns to 1; no Step after that.
- REPEAT_EN=0: hold 40 cycles -> exactly one Step; Release_pulse on release.
- Reset mid-repeat: assert Clr in REPEAT while KEY_N=0, then deassert -> outputs 0 immediately; Press_pulse and Step at edge 6 after deassertion.
